// File: rtl/rv_rf_pkg.sv
// Shared types and constants for the integer register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv_rf_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot decode of a register index with bit 0 suppressed, since x0 never
  // takes a write and never becomes busy.
  function automatic reg_mask_t onehot_nz(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue of a destination, cleared on writeback.
// Latency: set/clear visible one cycle after the edge; same-edge set beats clear.
// Backpressure: none; issue and writeback are accepted every cycle.
module rf_scoreboard
  import rv_rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue,
  input  reg_idx_t  issue_rd,
  input  logic      we,
  input  reg_idx_t  waddr,
  output reg_mask_t busy_mask
);

  reg_mask_t set_vec;
  reg_mask_t clr_vec;
  reg_mask_t busy_nxt;

  // Clear first, then set, so a new producer issued on the writeback edge stays outstanding.
  always_comb begin
    set_vec  = issue ? onehot_nz(issue_rd) : '0;
    clr_vec  = we    ? onehot_nz(waddr)    : '0;
    busy_nxt = (busy_mask & ~clr_vec) | set_vec;
  end

  // Busy vector register; reset discards any in-flight set or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_nxt;
    end
  end

endmodule

// File: rtl/rv_reg_file.sv
// 32 x XLEN register file, 1 write / 2 combinational read ports, x0 hardwired to zero, busy scoreboard.
// Latency: write visible one cycle after the edge; reads combinational (RV_RF_BYPASS_EN adds write-through).
// Backpressure: none; every write and issue is accepted in the cycle presented.
module rv_reg_file
  import rv_rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            WE,
  input  logic [4:0]      WADDR,
  input  logic [XLEN-1:0] WDATA,
  input  logic [4:0]      RADDR1,
  output logic [XLEN-1:0] RDATA1,
  input  logic [4:0]      RADDR2,
  output logic [XLEN-1:0] RDATA2,
  input  logic            ISSUE,
  input  logic [4:0]      ISSUE_RD,
  output logic            BUSY1,
  output logic            BUSY2,
  output logic [31:0]     BUSY_MASK
);

  logic [XLEN-1:0] regs [NUM_REGS];
  reg_mask_t       we_vec;

  // Per-register write enables; bit 0 is never set, so regs[0] holds its reset zero forever.
  always_comb begin
    we_vec = WE ? onehot_nz(WADDR) : '0;
  end

  // Data array; reset clears every entry and drops any same-edge write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_vec[i]) begin
          regs[i] <= WDATA;
        end
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk       (CLK),
    .rst_n     (RST_N),
    .issue     (ISSUE),
    .issue_rd  (ISSUE_RD),
    .we        (WE),
    .waddr     (WADDR),
    .busy_mask (BUSY_MASK)
  );

`ifdef RV_RF_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Write-through: a same-cycle write to the read index is forwarded and the port
  // reports not-busy, unless a new producer for that index issues in the same cycle.
  always_comb begin
    fwd1   = we_vec[RADDR1];
    fwd2   = we_vec[RADDR2];
    RDATA1 = fwd1 ? WDATA : regs[RADDR1];
    RDATA2 = fwd2 ? WDATA : regs[RADDR2];
    BUSY1  = BUSY_MASK[RADDR1];
    BUSY2  = BUSY_MASK[RADDR2];
    if (fwd1 && !(ISSUE && (ISSUE_RD == RADDR1))) BUSY1 = 1'b0;
    if (fwd2 && !(ISSUE && (ISSUE_RD == RADDR2))) BUSY2 = 1'b0;
  end
`else
  // Plain read ports: pre-edge state only, a same-cycle write shows up next cycle.
  always_comb begin
    RDATA1 = regs[RADDR1];
    RDATA2 = regs[RADDR2];
    BUSY1  = BUSY_MASK[RADDR1];
    BUSY2  = BUSY_MASK[RADDR2];
  end
`endif

endmodule

// File: tb/tb_rv_reg_file.sv
// Directed, table-driven bench for rv_reg_file plus hand sequences for reset and sweep.
// Latency: inputs driven after the falling edge, outputs sampled 2 time units later.
// Backpressure: not applicable.
module tb_rv_reg_file;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WE;
  logic [4:0]  WADDR;
  logic [31:0] WDATA;
  logic [4:0]  RADDR1;
  logic [31:0] RDATA1;
  logic [4:0]  RADDR2;
  logic [31:0] RDATA2;
  logic        ISSUE;
  logic [4:0]  ISSUE_RD;
  logic        BUSY1;
  logic        BUSY2;
  logic [31:0] BUSY_MASK;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [32];

  always #5 CLK = ~CLK;

  rv_reg_file #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WE        (WE),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .RADDR1    (RADDR1),
    .RDATA1    (RDATA1),
    .RADDR2    (RADDR2),
    .RDATA2    (RDATA2),
    .ISSUE     (ISSUE),
    .ISSUE_RD  (ISSUE_RD),
    .BUSY1     (BUSY1),
    .BUSY2     (BUSY2),
    .BUSY_MASK (BUSY_MASK)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_mask;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic issue, input logic [4:0] issue_rd,
                              input logic [4:0] raddr1, input logic [4:0] raddr2,
                              input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                              input logic e_b1, input logic e_b2, input logic [31:0] e_mask);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.issue = issue; v.issue_rd = issue_rd;
    v.raddr1 = raddr1; v.raddr2 = raddr2; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
    v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic issue, input logic [4:0] issue_rd,
                       input logic [4:0] raddr1, input logic [4:0] raddr2);
    @(negedge CLK);
    WE = we; WADDR = waddr; WDATA = wdata; ISSUE = issue; ISSUE_RD = issue_rd;
    RADDR1 = raddr1; RADDR2 = raddr2;
    #2;
  endtask

  initial begin
    RST_N = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0; ISSUE = 1'b0; ISSUE_RD = '0;
    RADDR1 = '0; RADDR2 = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    // Reset state
    RADDR1 = 5'd3; RADDR2 = 5'd17;
    #12;
    chk("reset rdata1", RDATA1, 32'h0);
    chk("reset rdata2", RDATA2, 32'h0);
    chk("reset busy1", {31'b0, BUSY1}, 32'h0);
    chk("reset busy2", {31'b0, BUSY2}, 32'h0);
    chk("reset mask", BUSY_MASK, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // we, waddr, wdata, issue, issue_rd, raddr1, raddr2, e_rd1, e_rd2, e_b1, e_b2, e_mask
    tbl[0]  = mk(1, 0,  32'hFFFF_FFFF, 1, 0, 0,  0,  32'h0,          32'h0,          0, 0, 32'h0);
    tbl[1]  = mk(0, 0,  32'h0,         0, 0, 0,  3,  32'h0,          32'h0,          0, 0, 32'h0);
    tbl[2]  = mk(0, 0,  32'h0,         1, 7, 7,  0,  32'h0,          32'h0,          0, 0, 32'h0);
    tbl[3]  = mk(0, 0,  32'h0,         0, 0, 7,  7,  32'h0,          32'h0,          1, 1, 32'h0000_0080);
    tbl[4]  = mk(0, 0,  32'h0,         0, 0, 7,  0,  32'h0,          32'h0,          1, 0, 32'h0000_0080);
    tbl[5]  = mk(1, 7,  32'h0000_0077, 0, 0, 3,  0,  32'h0,          32'h0,          0, 0, 32'h0000_0080);
    tbl[6]  = mk(0, 0,  32'h0,         0, 0, 7,  0,  32'h0000_0077,  32'h0,          0, 0, 32'h0);
    tbl[7]  = mk(0, 0,  32'h0,         1, 9, 9,  7,  32'h0,          32'h0000_0077,  0, 0, 32'h0);
    tbl[8]  = mk(1, 9,  32'h0000_0099, 1, 9, 7,  0,  32'h0000_0077,  32'h0,          0, 0, 32'h0000_0200);
    tbl[9]  = mk(0, 0,  32'h0,         0, 0, 9,  9,  32'h0000_0099,  32'h0000_0099,  1, 1, 32'h0000_0200);
    tbl[10] = mk(1, 12, 32'h1234_5678, 0, 0, 9,  0,  32'h0000_0099,  32'h0,          1, 0, 32'h0000_0200);
    tbl[11] = mk(0, 0,  32'h0,         0, 0, 12, 12, 32'h1234_5678,  32'h1234_5678,  0, 0, 32'h0000_0200);
    tbl[12] = mk(1, 9,  32'h0000_AAAA, 0, 0, 12, 12, 32'h1234_5678,  32'h1234_5678,  0, 0, 32'h0000_0200);
    tbl[13] = mk(0, 0,  32'h0,         0, 0, 9,  12, 32'h0000_AAAA,  32'h1234_5678,  0, 0, 32'h0);

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].we, tbl[k].waddr, tbl[k].wdata, tbl[k].issue, tbl[k].issue_rd,
            tbl[k].raddr1, tbl[k].raddr2);
      chk($sformatf("v%0d rdata1", k), RDATA1, tbl[k].e_rd1);
      chk($sformatf("v%0d rdata2", k), RDATA2, tbl[k].e_rd2);
      chk($sformatf("v%0d busy1", k), {31'b0, BUSY1}, {31'b0, tbl[k].e_b1});
      chk($sformatf("v%0d busy2", k), {31'b0, BUSY2}, {31'b0, tbl[k].e_b2});
      chk($sformatf("v%0d mask", k), BUSY_MASK, tbl[k].e_mask);
      if (tbl[k].we && tbl[k].waddr != 5'd0) mdl[tbl[k].waddr] = tbl[k].wdata;
    end

    // Dual-port same address: both busy flags agree
    drive(0, 0, 32'h0, 0, 0, 12, 12);
    chk("dual busy1==busy2", {31'b0, BUSY1}, {31'b0, BUSY2});

    // Sweep: write i*0x01010101 to every register, reading the same index in the same cycle
    for (int i = 1; i < 32; i++) begin
      logic [31:0] wd;
      logic [31:0] ex;
      wd = 32'h0101_0101 * i;
`ifdef RV_RF_BYPASS_EN
      ex = wd;
`else
      ex = mdl[i];
`endif
      drive(1, 5'(i), wd, 0, 0, 5'(i), 5'(i));
      chk($sformatf("sweep same-cycle r%0d port1", i), RDATA1, ex);
      chk($sformatf("sweep same-cycle r%0d port2", i), RDATA2, ex);
      mdl[i] = wd;
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 32'h0, 0, 0, 5'(i), 5'(31 - i));
      chk($sformatf("sweep read r%0d port1", i), RDATA1, mdl[i]);
      chk($sformatf("sweep read r%0d port2", 31 - i), RDATA2, mdl[31 - i]);
    end

    // Mid-operation reset: make reg 20 busy, then assert reset under an in-flight write and issue
    drive(0, 0, 32'h0, 1, 20, 20, 5);
    drive(0, 0, 32'h0, 0, 0, 20, 5);
    chk("pre-reset busy r20", {31'b0, BUSY1}, 32'h1);
    chk("pre-reset r5", RDATA2, 32'h0505_0505);
    drive(1, 5, 32'hDEAD_BEEF, 1, 5, 5, 20);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1; WE = 1'b0; ISSUE = 1'b0;
    #2;
    chk("post-reset r5", RDATA1, 32'h0);
    chk("post-reset r20", RDATA2, 32'h0);
    chk("post-reset mask", BUSY_MASK, 32'h0);

    // First edge after release performs normal updates
    drive(1, 5, 32'h0000_0055, 1, 6, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 5, 6);
    chk("after-release r5", RDATA1, 32'h0000_0055);
    chk("after-release busy r6", {31'b0, BUSY2}, 32'h1);
    chk("after-release mask", BUSY_MASK, 32'h0000_0040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
